qrng_conditioner: RTL and testbench



---
 rtl/qrng_conditioner.sv | 117 +++++++++++
 tb/tb_qrng_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/qrng_conditioner.sv
// qrng_conditioner: conditions the raw QRNG comparator bit into a stream of bytes.
// The raw bit is synchronised and decimated into samples. Samples pass through an
// optional von Neumann extractor, a repetition-count health test, and an LSB-first packer.
// Define QRNG_VN_DEBIAS_EN to put the extractor in the path; otherwise every sample is packed.
// Ports:
//   clk, rst (async, active-high)
//   ena         run enable; freezes divider, pair state, packer and health counter
//   raw_in      raw entropy bit (asynchronous to clk)
//   health_clr  clears a latched health failure
//   out_ready / out_valid / out_data  byte output handshake
//   health_fail sticky repetition-count failure
//   drop_cnt    saturating count of bytes lost to backpressure
module qrng_conditioner #(
  parameter int SAMPLE_DIV = 4,
  parameter int RCT_LIMIT  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       raw_in,
  input  logic       health_clr,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       health_fail,
  output logic [7:0] drop_cnt
);
  logic       sync_q, sync_d, raw_s_q, raw_s_d;
  logic [7:0] div_q, div_d;
  logic       prev_q, prev_d;
  logic [7:0] rep_q, rep_d, rep_n;
  logic       fail_q, fail_d;
  logic [6:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [7:0] drop_q, drop_d;
  logic       tick, fail_det, emit, emit_g, ebit, done, load;
  logic [7:0] byte_v;
`ifdef QRNG_VN_DEBIAS_EN
  logic       have_q, have_d, first_q, first_d;
`endif
  always_comb begin
    sync_d   = raw_in;
    raw_s_d  = sync_q;
    tick     = ena && div_q == 8'(SAMPLE_DIV - 1);
    div_d    = !ena ? div_q : tick ? 8'd0 : div_q + 8'd1;
    rep_n    = raw_s_q != prev_q ? 8'd1 : rep_q == 8'(RCT_LIMIT) ? rep_q : rep_q + 8'd1;
    fail_det = tick && rep_n == 8'(RCT_LIMIT);
    prev_d   = tick ? raw_s_q : prev_q;
    // a failure detected together with a clear keeps the new run length
    rep_d    = health_clr && !fail_det ? 8'd0 : tick ? rep_n : rep_q;
    fail_d   = fail_det || (fail_q && !health_clr);
`ifdef QRNG_VN_DEBIAS_EN
    // second sample of a pair: emit the first sample when the two differ
    emit     = tick && have_q && first_q != raw_s_q;
    ebit     = first_q;
    have_d   = fail_q ? 1'b0 : tick ? !have_q : have_q;
    first_d  = fail_q ? 1'b0 : tick && !have_q ? raw_s_q : first_q;
`else
    emit     = tick;
    ebit     = raw_s_q;
`endif
    emit_g   = emit && !fail_q;
    done     = emit_g && cnt_q == 3'd7;
    // right shift so the earliest bit ends up in bit 0 of the finished byte
    byte_v   = {ebit, acc_q};
    acc_d    = fail_q || done ? 7'd0 : emit_g ? byte_v[7:1] : acc_q;
    cnt_d    = fail_q ? 3'd0 : emit_g ? cnt_q + 3'd1 : cnt_q;
    load     = done && (!valid_q || out_ready);
    data_d   = load ? byte_v : data_q;
    valid_d  = load || (valid_q && !out_ready);
    drop_d   = done && !load && drop_q != 8'hff ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 1'b0;
      raw_s_q <= 1'b0;
      div_q   <= 8'd0;
      prev_q  <= 1'b0;
      rep_q   <= 8'd0;
      fail_q  <= 1'b0;
      acc_q   <= 7'd0;
      cnt_q   <= 3'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      sync_q  <= sync_d;
      raw_s_q <= raw_s_d;
      div_q   <= div_d;
      prev_q  <= prev_d;
      rep_q   <= rep_d;
      fail_q  <= fail_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end
`ifdef QRNG_VN_DEBIAS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      have_q  <= have_d;
      first_q <= first_d;
    end
  end
`endif
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign health_fail = fail_q;
  assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_qrng_conditioner.sv
// tb_qrng_conditioner: table-driven, directed and random checks of qrng_conditioner.
module tb_qrng_conditioner;
  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, raw_in = 1'b0, health_clr = 1'b0, out_ready = 1'b1;
  logic [7:0] od0, od1, dc0, dc1;
  logic ov0, ov1, hf0, hf1;
  always #5 clk = ~clk;
  qrng_conditioner #(.SAMPLE_DIV(1), .RCT_LIMIT(32)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .raw_in(raw_in), .health_clr(health_clr),
    .out_ready(out_ready), .out_data(od0), .out_valid(ov0), .health_fail(hf0), .drop_cnt(dc0));
  qrng_conditioner #(.SAMPLE_DIV(3), .RCT_LIMIT(4)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .raw_in(raw_in), .health_clr(health_clr),
    .out_ready(out_ready), .out_data(od1), .out_valid(ov1), .health_fail(hf1), .drop_cnt(dc1));
  int n_cmp = 0, n_bad = 0, xfer = 0, nvalid = 0;
  logic [7:0] first_x = 8'h00, last_x = 8'h00;
  int m_en[2], m_run[2], m_pn[2], m_nb[2], m_drop[2];
  bit m_last[2], m_fail[2], m_pv[2], m_valid[2];
  logic [7:0] m_acc[2], m_data[2];
  bit h1 = 0, h2 = 0;
  typedef struct { logic [63:0] bits; int n; logic rdy; logic [7:0] first; int cnt; int drop; } vec_t;
  vec_t tv[4];
  function automatic int dv(input int j); return j != 0 ? 3 : 1; endfunction
  function automatic int lim(input int j); return j != 0 ? 4 : 32; endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // Reference: each edge takes the sample driven two cycles earlier, runs the health
  // rule, pairs samples, and packs emitted bits LSB-first.
  task automatic model_edge();
    bit s;
    s = h2;
    for (int j = 0; j < 2; j++) begin
      bit tick, det, of, emit, b, done, load;
      logic [7:0] byt;
      if (rst) begin
        m_en[j] = 0; m_run[j] = 0; m_pn[j] = 0; m_nb[j] = 0; m_drop[j] = 0;
        m_last[j] = 0; m_fail[j] = 0; m_pv[j] = 0; m_valid[j] = 0;
        m_acc[j] = 0; m_data[j] = 0;
        continue;
      end
      tick = ena && (m_en[j] % dv(j) == dv(j) - 1);
      if (ena) m_en[j]++;
      of = m_fail[j]; det = 0; emit = 0; b = 0; done = 0; byt = 0;
      if (tick) begin
        m_run[j] = (s == m_last[j]) ? m_run[j] + 1 : 1;
        m_last[j] = s;
        det = m_run[j] >= lim(j);
      end
      if (health_clr && !det) m_run[j] = 0;
      m_fail[j] = det || (of && !health_clr);
      if (of) begin
        m_pn[j] = 0; m_nb[j] = 0; m_acc[j] = 0;
      end else if (tick) begin
`ifdef QRNG_VN_DEBIAS_EN
        if (m_pn[j] == 0) begin m_pv[j] = s; m_pn[j] = 1; end
        else begin m_pn[j] = 0; emit = m_pv[j] != s; b = m_pv[j]; end
`else
        emit = 1; b = s;
`endif
      end
      if (emit) begin
        m_acc[j][m_nb[j]] = b;
        m_nb[j]++;
        if (m_nb[j] == 8) begin done = 1; byt = m_acc[j]; m_nb[j] = 0; m_acc[j] = 0; end
      end
      load = done && (!m_valid[j] || out_ready);
      if (load) begin m_data[j] = byt; m_valid[j] = 1; end
      else if (m_valid[j] && out_ready) m_valid[j] = 0;
      if (done && !load && m_drop[j] < 255) m_drop[j]++;
    end
    if (rst) begin h1 = 0; h2 = 0; end
    else begin h2 = h1; h1 = raw_in; end
  endtask
  task automatic step();
    if (ov0 && out_ready) begin
      if (xfer == 0) first_x = od0;
      last_x = od0;
      xfer++;
    end
    @(posedge clk);
    model_edge();
    #1;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("dut%0d out_data", j), j != 0 ? od1 : od0, m_data[j]);
      chk($sformatf("dut%0d out_valid", j), j != 0 ? ov1 : ov0, m_valid[j]);
      chk($sformatf("dut%0d health_fail", j), j != 0 ? hf1 : hf0, m_fail[j]);
      chk($sformatf("dut%0d drop_cnt", j), j != 0 ? dc1 : dc0, m_drop[j]);
    end
    if (ov0) nvalid++;
  endtask
  // Two leading disabled cycles preload the synchroniser so exactly n samples are taken.
  task automatic feed(input logic [63:0] bits, input int n);
    for (int i = 0; i < n + 2; i++) begin
      raw_in = i < n ? bits[i] : 1'b0;
      ena = i >= 2;
      step();
    end
    ena = 0;
  endtask
  task automatic drain(input int k);
    ena = 0;
    for (int i = 0; i < k; i++) step();
  endtask
  task automatic do_reset();
    rst = 1; ena = 0; health_clr = 0; out_ready = 1;
    step(); step();
    rst = 0;
    step();
  endtask
  initial begin
    int mode;
`ifdef QRNG_VN_DEBIAS_EN
    tv[0] = '{64'h5555, 16, 1'b1, 8'hFF, 1, 0};
    tv[1] = '{64'h55CAA, 20, 1'b1, 8'hF0, 1, 0};
    tv[2] = '{64'hAAAA, 16, 1'b1, 8'h00, 1, 0};
    tv[3] = '{64'h5555AA55, 32, 1'b0, 8'h0F, 0, 1};
`else
    tv[0] = '{64'h5555, 16, 1'b1, 8'h55, 2, 0};
    tv[1] = '{64'h55CAA, 20, 1'b1, 8'hAA, 2, 0};
    tv[2] = '{64'hAAAA, 16, 1'b1, 8'hAA, 2, 0};
    tv[3] = '{64'h5555AA55, 32, 1'b0, 8'h55, 0, 3};
`endif
    do_reset();
    chk("reset out_data", od0, 0);
    chk("reset out_valid", ov0, 0);
    chk("reset health_fail", hf0, 0);
    chk("reset drop_cnt", dc0, 0);
    for (int k = 0; k < 4; k++) begin
      do_reset();
      out_ready = tv[k].rdy; xfer = 0; nvalid = 0; first_x = 8'h00;
      feed(tv[k].bits, tv[k].n);
      if (tv[k].rdy) begin
        drain(3);
        chk($sformatf("vec%0d bytes", k), xfer, tv[k].cnt);
        chk($sformatf("vec%0d valid cycles", k), nvalid, tv[k].cnt);
        chk($sformatf("vec%0d first byte", k), first_x, tv[k].first);
        chk($sformatf("vec%0d drop_cnt", k), dc0, tv[k].drop);
      end else begin
        chk($sformatf("vec%0d held byte", k), od0, tv[k].first);
        chk($sformatf("vec%0d held valid", k), ov0, 1);
        chk($sformatf("vec%0d drop_cnt", k), dc0, tv[k].drop);
        out_ready = 1; step(); out_ready = 0;
        chk($sformatf("vec%0d valid after drain", k), ov0, 0);
        chk($sformatf("vec%0d drained bytes", k), xfer, 1);
        out_ready = 1;
      end
    end
    do_reset();
    feed({64{1'b1}}, 31);
    chk("rct before limit", hf0, 0);
    feed({64{1'b1}}, 1);
    chk("rct at limit", hf0, 1);
    nvalid = 0;
    feed(64'h5555, 16);
    drain(2);
    chk("no bytes while failed", nvalid, 0);
    chk("fail sticky", hf0, 1);
    health_clr = 1; step(); health_clr = 0;
    chk("fail cleared", hf0, 0);
    xfer = 0;
    feed(64'h5555, 16);
    drain(3);
`ifdef QRNG_VN_DEBIAS_EN
    chk("resume bytes", xfer, 1);
    chk("resume byte", last_x, 8'hFF);
`else
    chk("resume bytes", xfer, 2);
    chk("resume byte", last_x, 8'h55);
`endif
    feed(64'h155, 10);
    rst = 1; #1;
    chk("async rst out_data", od0, 0);
    chk("async rst out_valid", ov0, 0);
    chk("async rst health_fail", hf0, 0);
    chk("async rst drop_cnt", dc0, 0);
    step(); rst = 0; step();
    xfer = 0;
    feed(64'h5555, 16);
    drain(3);
`ifdef QRNG_VN_DEBIAS_EN
    chk("post-reset bytes", xfer, 1);
    chk("post-reset byte", last_x, 8'hFF);
`else
    chk("post-reset bytes", xfer, 2);
    chk("post-reset byte", last_x, 8'h55);
`endif
    do_reset();
    xfer = 0;
    feed(64'h55, 8);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin raw_in = 1'($urandom); step(); end
    chk("no output while disabled", nvalid, 0);
    feed(64'h55, 8);
    drain(3);
`ifdef QRNG_VN_DEBIAS_EN
    chk("gated bytes", xfer, 1);
    chk("gated byte", last_x, 8'hFF);
`else
    chk("gated bytes", xfer, 2);
    chk("gated byte", last_x, 8'h55);
`endif
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) mode = int'($urandom % 3);
      ena = ($urandom % 8) != 0;
      raw_in = mode == 0 ? 1'($urandom) : mode == 1 ? (($urandom % 16) != 0) : raw_in;
      out_ready = ($urandom % 4) != 0;
      health_clr = !ena && ($urandom % 3) == 0;
      rst = ($urandom % 1500) == 0;
      step();
    end
    rst = 0; ena = 0; health_clr = 1; step(); health_clr = 0;
    out_ready = 0; ena = 1;
    for (int c = 0; c < 10000; c++) begin raw_in = 1'($urandom); step(); end
    chk("drop_cnt saturates", dc0, 8'hFF);
    out_ready = 1; ena = 0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
